// File: rtl/noc_pkg.sv
// Shared types and framing helpers for the NoC credit-based link.
package noc_pkg;

    // Default payload width for the packed flit record.
    localparam int NOC_FLIT_W = 32;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } tx_state_e;

    typedef struct packed {
        flit_type_e             flit_type;
        logic [NOC_FLIT_W-1:0]  data;
    } flit_t;

    // A flit is well framed if it opens a packet outside one, or continues/closes one inside.
    function automatic logic frame_legal(input tx_state_e st, input flit_type_e ft);
        logic ok;
        ok = 1'b0;
        case (st)
            IDLE:    ok = (ft == HEAD) || (ft == SINGLE);
            IN_PKT:  ok = (ft == BODY) || (ft == TAIL);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Framing state after a legal flit of the given type has been sent.
    function automatic tx_state_e frame_next(input tx_state_e st, input flit_type_e ft);
        tx_state_e nx;
        nx = st;
        case (ft)
            HEAD:    nx = IN_PKT;
            TAIL:    nx = IDLE;
            default: nx = st;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Saturating up/down credit counter; starts (and clears) full at MAX.
module noc_credit_counter
    import noc_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         up,
    input  logic                         down,
    output logic [$clog2(MAX+1)-1:0]     count,
    output logic                         at_max,
    output logic                         at_zero,
    output logic                         overflow
);

    localparam int W = $clog2(MAX + 1);

    assign at_max   = (count == W'(MAX));
    assign at_zero  = (count == '0);
    // A lone return while already full cannot be counted; flag it instead.
    assign overflow = up && !down && at_max && !clear;

    // Count register: simultaneous up/down cancel, both directions saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= W'(MAX);
        end else if (clear) begin
            count <= W'(MAX);
        end else if (up && !down && !at_max) begin
            count <= count + W'(1);
        end else if (down && !up && !at_zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/noc_credit_tx.sv
// Credit-based NoC link transmitter with packet framing checks and sticky error flags.
module noc_credit_tx
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH    = 32,
    parameter int CREDITS       = 8,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_clear,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [1:0]                     i_flit_type,
    input  logic [FLIT_WIDTH-1:0]          i_flit_data,
    output logic                           o_flit_valid,
    output logic [1:0]                     o_flit_type,
    output logic [FLIT_WIDTH-1:0]          o_flit_data,
    input  logic                           i_credit_return,
    output logic [$clog2(CREDITS+1)-1:0]   o_credit_count,
    output logic                           o_frame_err,
    output logic                           o_credit_err,
    output logic [PKT_CNT_WIDTH-1:0]       o_pkt_cnt
);

    tx_state_e  state;
    tx_state_e  state_nxt;
    flit_type_e in_type;
    logic       accept;
    logic       send;
    logic       drop;
    logic       pkt_done;
    logic       at_zero;
    logic       unused_at_max;
    logic       credit_ovf;

    logic                  vld_p1;
    logic [1:0]            flit_type_p1;
    logic [FLIT_WIDTH-1:0] flit_data_p1;

    assign in_type = flit_type_e'(i_flit_type);
    // Readiness looks only at the registered count, never at a same-cycle return.
    assign o_ready = !at_zero && !i_clear;
    assign accept  = i_valid && o_ready;

    noc_credit_counter #(
        .MAX (CREDITS)
    ) u_credits (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (i_clear),
        .up       (i_credit_return),
        .down     (send),
        .count    (o_credit_count),
        .at_max   (unused_at_max),
        .at_zero  (at_zero),
        .overflow (credit_ovf)
    );

    // Framing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (i_clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next framing state: only legally sent flits move the FSM.
    always_comb begin
        state_nxt = state;
        if (send) begin
            state_nxt = frame_next(state, in_type);
        end
    end

    // FSM outputs: classify each accepted flit as sent or dropped.
    always_comb begin
        send     = 1'b0;
        drop     = 1'b0;
        pkt_done = 1'b0;
        if (accept) begin
            if (frame_legal(state, in_type)) begin
                send     = 1'b1;
                pkt_done = (in_type == TAIL) || (in_type == SINGLE);
            end else begin
                drop = 1'b1;
            end
        end
    end

    // ---- stage p1: registered link flit ----
    // Link output register; payload and type hold when nothing is sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            flit_type_p1 <= 2'b00;
            flit_data_p1 <= '0;
        end else if (i_clear) begin
            vld_p1       <= 1'b0;
            flit_type_p1 <= 2'b00;
            flit_data_p1 <= '0;
        end else begin
            vld_p1 <= send;
            if (send) begin
                flit_type_p1 <= i_flit_type;
                flit_data_p1 <= i_flit_data;
            end
        end
    end

    assign o_flit_valid = vld_p1;
    assign o_flit_type  = flit_type_p1;
    assign o_flit_data  = flit_data_p1;

    // Sticky error flags and wrapping packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_frame_err  <= 1'b0;
            o_credit_err <= 1'b0;
            o_pkt_cnt    <= '0;
        end else if (i_clear) begin
            o_frame_err  <= 1'b0;
            o_credit_err <= 1'b0;
            o_pkt_cnt    <= '0;
        end else begin
            if (drop) begin
                o_frame_err <= 1'b1;
            end
            if (credit_ovf) begin
                o_credit_err <= 1'b1;
            end
            if (pkt_done) begin
                o_pkt_cnt <= o_pkt_cnt + PKT_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_noc_credit_tx.sv
// Self-checking bench for noc_credit_tx: directed scenarios plus randomized traffic.
module tb_noc_credit_tx;
    import noc_pkg::*;

    localparam int FW  = 32;
    localparam int CR  = 8;
    localparam int PW  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_clear = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [1:0]    i_flit_type = 2'b00;
    logic [FW-1:0] i_flit_data = '0;
    logic          o_flit_valid;
    logic [1:0]    o_flit_type;
    logic [FW-1:0] o_flit_data;
    logic          i_credit_return = 1'b0;
    logic [3:0]    o_credit_count;
    logic          o_frame_err;
    logic          o_credit_err;
    logic [PW-1:0] o_pkt_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    noc_credit_tx #(.FLIT_WIDTH(FW), .CREDITS(CR), .PKT_CNT_WIDTH(PW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_clear         (i_clear),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_flit_type     (i_flit_type),
        .i_flit_data     (i_flit_data),
        .o_flit_valid    (o_flit_valid),
        .o_flit_type     (o_flit_type),
        .o_flit_data     (o_flit_data),
        .i_credit_return (i_credit_return),
        .o_credit_count  (o_credit_count),
        .o_frame_err     (o_frame_err),
        .o_credit_err    (o_credit_err),
        .o_pkt_cnt       (o_pkt_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: plain counters and a "inside a packet" bit.
    typedef struct {
        int    credits;
        bit    in_pkt;
        bit    ferr;
        bit    cerr;
        int    pkts;
        bit    vld;
        flit_t flit;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.credits = CR;
        r.in_pkt  = 1'b0;
        r.ferr    = 1'b0;
        r.cerr    = 1'b0;
        r.pkts    = 0;
        r.vld     = 1'b0;
        r.flit    = '0;
        return r;
    endfunction

    function automatic model_t model_step(model_t s, bit clr, bit v, logic [1:0] t,
                                          logic [FW-1:0] d, bit ret);
        model_t r;
        bit took;
        bit ok;
        r = s;
        if (clr) return model_reset();
        took = v && (s.credits > 0);
        if (s.in_pkt) ok = (t == 2'b00) || (t == 2'b10);
        else          ok = (t == 2'b01) || (t == 2'b11);
        ok = ok && took;
        r.vld = ok;
        if (took && !ok) r.ferr = 1'b1;
        if (ok) begin
            r.flit.flit_type = flit_type_e'(t);
            r.flit.data      = d;
            if (t == 2'b01) r.in_pkt = 1'b1;
            if (t == 2'b10) r.in_pkt = 1'b0;
            if (t == 2'b10 || t == 2'b11) r.pkts = (s.pkts + 1) % (1 << PW);
        end
        if (ok && !ret) r.credits = s.credits - 1;
        else if (ret && !ok) begin
            if (s.credits == CR) r.cerr = 1'b1;
            else                 r.credits = s.credits + 1;
        end
        return r;
    endfunction

    // Model advances on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, i_clear, i_valid, i_flit_type, i_flit_data, i_credit_return);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid",  64'(o_flit_valid),   64'(m.vld));
            chk("m_type",   64'(o_flit_type),    64'(m.flit.flit_type));
            chk("m_data",   64'(o_flit_data),    64'(m.flit.data));
            chk("m_credit", 64'(o_credit_count), 64'(m.credits));
            chk("m_ready",  64'(o_ready),        64'((m.credits != 0) && !i_clear));
            chk("m_ferr",   64'(o_frame_err),    64'(m.ferr));
            chk("m_cerr",   64'(o_credit_err),   64'(m.cerr));
            chk("m_pkt",    64'(o_pkt_cnt),      64'(m.pkts));
        end
    end

    // One clock of stimulus; inputs return to idle just after the edge.
    task automatic tick(input bit v, input logic [1:0] t, input logic [FW-1:0] d,
                        input bit ret, input bit clr);
        i_valid         = v;
        i_flit_type     = t;
        i_flit_data     = d;
        i_credit_return = ret;
        i_clear         = clr;
        @(posedge clk);
        #1;
        i_valid         = 1'b0;
        i_credit_return = 1'b0;
        i_clear         = 1'b0;
    endtask

    task automatic returns(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 2'b00, '0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #2;
        chk("rst_credit", 64'(o_credit_count), 64'd8);
        chk("rst_valid",  64'(o_flit_valid),   64'd0);
        chk("rst_pkt",    64'(o_pkt_cnt),      64'd0);
        chk("rst_ready",  64'(o_ready),        64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Full packet of eight flits back-to-back, no returns.
        tick(1'b1, 2'b01, 32'h1000_0000, 1'b0, 1'b0);
        chk("pkt_head_v", 64'(o_flit_valid), 64'd1);
        chk("pkt_head_t", 64'(o_flit_type),  64'd1);
        chk("pkt_head_d", 64'(o_flit_data),  64'h1000_0000);
        for (int k = 1; k <= 6; k++) begin
            tick(1'b1, 2'b00, 32'h1000_0000 + 32'(k), 1'b0, 1'b0);
            chk("pkt_body_v", 64'(o_flit_valid), 64'd1);
            chk("pkt_body_d", 64'(o_flit_data),  64'h1000_0000 + 64'(k));
        end
        tick(1'b1, 2'b10, 32'h1000_00FF, 1'b0, 1'b0);
        chk("pkt_tail_t", 64'(o_flit_type),    64'd2);
        chk("pkt_cred0",  64'(o_credit_count), 64'd0);
        chk("pkt_ready0", 64'(o_ready),        64'd0);
        chk("pkt_cnt1",   64'(o_pkt_cnt),      64'd1);
        tick(1'b1, 2'b11, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("stall_v",    64'(o_flit_valid),   64'd0);
        chk("stall_hold", 64'(o_flit_data),    64'h1000_00FF);

        // Single credit return reopens the link for one flit.
        returns(1);
        chk("ret_cred1",  64'(o_credit_count), 64'd1);
        chk("ret_ready",  64'(o_ready),        64'd1);
        tick(1'b1, 2'b11, 32'h0000_0011, 1'b0, 1'b0);
        chk("ret_send_v", 64'(o_flit_valid),   64'd1);
        chk("ret_cred0",  64'(o_credit_count), 64'd0);

        // Send and return in the same cycle leave the count at 3.
        returns(3);
        chk("sim_cred3a", 64'(o_credit_count), 64'd3);
        tick(1'b1, 2'b01, 32'h0000_0022, 1'b1, 1'b0);
        tick(1'b1, 2'b00, 32'h0000_0033, 1'b1, 1'b0);
        chk("sim_body_v", 64'(o_flit_valid),   64'd1);
        chk("sim_body_d", 64'(o_flit_data),    64'h33);
        chk("sim_cred3b", 64'(o_credit_count), 64'd3);
        tick(1'b1, 2'b10, 32'h0000_0044, 1'b1, 1'b0);
        chk("sim_pkt3",   64'(o_pkt_cnt),      64'd3);

        // Framing error in IDLE, then a good SINGLE.
        tick(1'b1, 2'b00, 32'h0000_00A5, 1'b0, 1'b0);
        chk("fe_valid",   64'(o_flit_valid),   64'd0);
        chk("fe_flag",    64'(o_frame_err),    64'd1);
        chk("fe_cred",    64'(o_credit_count), 64'd3);
        tick(1'b1, 2'b11, 32'h0000_0055, 1'b0, 1'b0);
        chk("fe_single",  64'(o_flit_valid),   64'd1);
        chk("fe_pkt4",    64'(o_pkt_cnt),      64'd4);

        // Overfull return, then soft clear.
        returns(6);
        chk("ce_cred8",   64'(o_credit_count), 64'd8);
        chk("ce_none",    64'(o_credit_err),   64'd0);
        returns(1);
        chk("ce_sat",     64'(o_credit_count), 64'd8);
        chk("ce_flag",    64'(o_credit_err),   64'd1);
        tick(1'b0, 2'b00, '0, 1'b0, 1'b1);
        chk("clr_ferr",   64'(o_frame_err),    64'd0);
        chk("clr_cerr",   64'(o_credit_err),   64'd0);
        chk("clr_pkt",    64'(o_pkt_cnt),      64'd0);
        tick(1'b1, 2'b00, 32'h0000_0066, 1'b0, 1'b0);
        chk("clr_idle",   64'(o_frame_err),    64'd1);
        tick(1'b0, 2'b00, '0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a packet.
        tick(1'b1, 2'b01, 32'h0000_0077, 1'b0, 1'b0);
        tick(1'b1, 2'b00, 32'h0000_0088, 1'b0, 1'b0);
        tick(1'b1, 2'b00, 32'h0000_0099, 1'b0, 1'b0);
        chk("ar_cred5",   64'(o_credit_count), 64'd5);
        chk("ar_vld_pre", 64'(o_flit_valid),   64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_vld",     64'(o_flit_valid),   64'd0);
        chk("ar_cred8",   64'(o_credit_count), 64'd8);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1'b1, 2'b00, 32'h0000_00AA, 1'b0, 1'b0);
        chk("ar_body_v",  64'(o_flit_valid),   64'd0);
        chk("ar_body_fe", 64'(o_frame_err),    64'd1);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 350) begin
                #3 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            tick(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 99) < 2));
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
